// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory.
// Holds the fill/ready state encoding, the default fill word and the lane-rotate index.
// Combinational helpers only; no storage here.
package dmem_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_FILL = 32'hFFFF_FFFF;

  // Lane served by bank b for base address base: (b - base) mod lanes.
  // lanes is a power of two, so unsigned wraparound plus a mask is exact.
  function automatic int unsigned rot_idx(int unsigned b, int unsigned base, int unsigned lanes);
    return (b - base) & (lanes - 1);
  endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// Request/response bundle between a master and the banked data memory.
// Request fields are sampled on the memory clock; q/q_valid arrive one cycle after a read.
// busy=1 means requests are dropped; the master must hold off rather than retry blindly.
interface dmem_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int LANES  = 4
);
  logic                       re;
  logic                       we;
  logic [ADDR_W-1:0]          a;
  logic [LANES-1:0]           lane_en;
  logic [LANES*DATA_W/8-1:0]  be;
  logic [LANES*DATA_W-1:0]    d;
  logic [LANES*DATA_W-1:0]    q;
  logic                       q_valid;
  logic                       busy;

  modport master (
    output re, we, a, lane_en, be, d,
    input  q, q_valid, busy
  );

  modport slave (
    input  re, we, a, lane_en, be, d,
    output q, q_valid, busy
  );
endinterface

// File: rtl/dmem_bank.sv
// One word-wide storage bank with byte-granular writes and a registered read port.
// Read latency 1; a read and write to the same row in one cycle returns the old contents.
// No backpressure: every enabled access completes in the cycle it is presented.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ROW_W-1:0]      row_i,
  input  logic [DATA_W-1:0]     wdat_i,
  output logic [DATA_W-1:0]     rdat_o
);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdat_q;

  // Byte-masked write; contents are not reset (the fill engine initialises them).
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_W/8; k++) begin
      if (be_i[k]) begin
        mem_q[row_i][k*8 +: 8] <= wdat_i[k*8 +: 8];
      end
    end
  end

  // Read register samples the pre-write row contents and holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
    end else if (rd_en_i) begin
      rdat_q <= mem_q[row_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/dmem_banked.sv
// Multi-lane word-interleaved data memory with a post-reset fill engine.
// Read latency 1 cycle (q/q_valid the edge after an accepted read); writes visible next cycle.
// While busy (fill running or reset) re/we are dropped silently; no queuing.
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 6,
  parameter int                 LANES  = 4,
  parameter logic [DATA_W-1:0]  FILL   = DATA_W'(DEFAULT_FILL)
) (
  input  logic          clk,
  input  logic          rst,
  dmem_banked_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LG    = $clog2(LANES);
  localparam int BPW   = DATA_W/8;
  localparam int ROWS  = DEPTH/LANES;
  localparam int ROW_W = (ADDR_W > LG) ? (ADDR_W - LG) : 1;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rot_q, rot_d;
  logic                q_valid_q, q_valid_d;

  logic                ready;
  logic                rd_acc;
  logic                wr_acc;

  logic [ROW_W-1:0]          bk_row  [LANES];
  logic [BPW-1:0]            bk_be   [LANES];
  logic [DATA_W-1:0]         bk_wdat [LANES];
  logic [LANES*DATA_W-1:0]   bk_rdat;
  logic [LANES*DATA_W-1:0]   q_c;

  assign ready  = (state_q == S_READY) && !rst;
  assign rd_acc = ready && bus.re;
  assign wr_acc = ready && bus.we;

  // Fill FSM state and row counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fill FSM next state: sweep every row once, then hand over to normal traffic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_FILL) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ROW_W'(ROWS - 1)) begin
        state_d = S_READY;
        cnt_d   = '0;
      end
    end
  end

  // Per-bank address/data steering: bank b serves lane (b - a) mod LANES.
  always_comb begin
    int unsigned       lane;
    logic [ADDR_W-1:0] word;
    logic [LANES-1:0]  en_vec;
    for (int unsigned b = 0; b < LANES; b++) begin
      lane       = rot_idx(b, 32'(bus.a), LANES);
      word       = bus.a + ADDR_W'(lane);
      en_vec     = bus.lane_en >> lane;
      bk_row[b]  = ROW_W'(word >> LG);
      bk_wdat[b] = DATA_W'(bus.d >> (lane * DATA_W));
      bk_be[b]   = BPW'(bus.be >> (lane * BPW)) & {BPW{wr_acc & en_vec[0]}};
      if (state_q == S_FILL) begin
        bk_row[b]  = cnt_q;
        bk_wdat[b] = FILL;
        bk_be[b]   = {BPW{!rst}};
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    dmem_bank #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .rd_en_i (rd_acc),
      .be_i    (bk_be[g]),
      .row_i   (bk_row[g]),
      .wdat_i  (bk_wdat[g]),
      .rdat_o  (bk_rdat[g*DATA_W +: DATA_W])
    );
  end

  assign rot_d     = rd_acc ? bus.a : rot_q;
  assign q_valid_d = rd_acc;

  // Read-side rotation register and q_valid pulse; both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q     <= '0;
      q_valid_q <= 1'b0;
    end else begin
      rot_q     <= rot_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Un-rotate bank outputs so lane i carries word (a + i) of the last accepted read.
  always_comb begin
    int unsigned b;
    q_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      b = (32'(rot_q) + i) & (LANES - 1);
      q_c[i*DATA_W +: DATA_W] = DATA_W'(bk_rdat >> (b * DATA_W));
    end
  end

  assign bus.q       = q_c;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = (state_q == S_FILL) || rst;

endmodule

// File: tb/tb_dmem_banked.sv
// Directed-vector bench for dmem_banked (DATA_W=32, ADDR_W=6, LANES=4).
// Inputs driven and outputs sampled on the falling edge; one table of vectors plus reset/fill sequences.
// Every wait is bounded by a cycle budget.
module tb_dmem_banked;

  localparam logic [31:0] F = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_banked_if #(.DATA_W(32), .ADDR_W(6), .LANES(4)) bus ();

  dmem_banked #(
    .DATA_W (32),
    .ADDR_W (6),
    .LANES  (4),
    .FILL   (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit           re;
    bit           we;
    logic [5:0]   a;
    logic [3:0]   len;
    logic [15:0]  be;
    logic [127:0] d;
    bit           chk_q;
    logic [127:0] exp_q;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit re, bit we, logic [5:0] a, logic [3:0] len, logic [15:0] be,
                              logic [127:0] d, bit chk_q, logic [127:0] exp_q);
    vec_t v;
    v.re = re; v.we = we; v.a = a; v.len = len; v.be = be;
    v.d = d; v.chk_q = chk_q; v.exp_q = exp_q;
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.re = 1'b0; bus.we = 1'b0; bus.a = '0;
    bus.lane_en = '0; bus.be = '0; bus.d = '0;
  endtask

  // Called at a falling edge right after rst is released; counts busy cycles.
  task automatic count_fill(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 100);
    check(name, 128'(n), 128'd16);
  endtask

  // Issue one read at this falling edge, check the response one cycle later.
  task automatic read_chk(string name, logic [5:0] a, logic [127:0] exp);
    bus.re = 1'b1; bus.a = a;
    @(negedge clk);
    bus.re = 1'b0;
    check({name, "_qv"}, 128'(bus.q_valid), 128'd1);
    check(name, bus.q, exp);
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1;

    // Fill-verification reads, every lane of every row.
    for (int k = 0; k < 16; k++) tv.push_back(mk(1, 0, 6'(4*k), 4'h0, 16'h0, '0, 1, {4{F}}));
    // Aligned write then read.
    tv.push_back(mk(0, 1, 6'd8, 4'hF, 16'hFFFF, {32'd4, 32'd3, 32'd2, 32'd1}, 0, '0));
    tv.push_back(mk(1, 0, 6'd8, 4'h0, 16'h0, '0, 1, {32'd4, 32'd3, 32'd2, 32'd1}));
    // Byte and lane masking over word 9.
    tv.push_back(mk(0, 1, 6'd9, 4'b0001, 16'h000F, {96'h0, 32'h2222_2222}, 0, '0));
    tv.push_back(mk(0, 1, 6'd9, 4'b0001, 16'hFFF5, {{3{32'h5555_5555}}, 32'hAABB_CCDD}, 0, '0));
    tv.push_back(mk(1, 0, 6'd8, 4'h0, 16'h0, '0, 1, {32'd4, 32'd3, 32'h22BB_22DD, 32'd1}));
    tv.push_back(mk(1, 0, 6'd12, 4'h0, 16'h0, '0, 1, {4{F}}));
    // Unaligned wrap: words 62,63,0,1.
    tv.push_back(mk(0, 1, 6'd62, 4'hF, 16'hFFFF,
                    {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0}, 0, '0));
    tv.push_back(mk(1, 0, 6'd62, 4'h0, 16'h0, '0, 1,
                    {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0}));
    tv.push_back(mk(1, 0, 6'd0, 4'h0, 16'h0, '0, 1, {F, F, 32'hD3D3_D3D3, 32'hC2C2_C2C2}));
    tv.push_back(mk(1, 0, 6'd60, 4'h0, 16'h0, '0, 1, {32'hB1B1_B1B1, 32'hA0A0_A0A0, F, F}));
    // Read-first on simultaneous read and write, then read back.
    tv.push_back(mk(1, 1, 6'd4, 4'hF, 16'hFFFF, {32'h44, 32'h43, 32'h42, 32'h41}, 1, {4{F}}));
    tv.push_back(mk(1, 0, 6'd4, 4'h0, 16'h0, '0, 1, {32'h44, 32'h43, 32'h42, 32'h41}));

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'd1);
    check("rst_q", bus.q, 128'd0);
    check("rst_qv", 128'(bus.q_valid), 128'd0);

    // Release reset with a read request that must be dropped during fill.
    rst = 1'b0;
    bus.re = 1'b1; bus.a = 6'd8;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("fill_re_qv", 128'(bus.q_valid), 128'd0);
        check("fill_re_q", bus.q, 128'd0);
        bus.re = 1'b0;
      end
    end while (bus.busy && n < 100);
    check("fill_cycles", 128'(n), 128'd16);

    // Table, applied back-to-back.
    foreach (tv[i]) begin
      bus.re = tv[i].re; bus.we = tv[i].we; bus.a = tv[i].a;
      bus.lane_en = tv[i].len; bus.be = tv[i].be; bus.d = tv[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_qv", i), 128'(bus.q_valid), 128'(tv[i].re));
      if (tv[i].chk_q) check($sformatf("vec%0d_q", i), bus.q, tv[i].exp_q);
    end
    idle();

    // q_valid is a single pulse and q holds afterwards.
    read_chk("hold_rd", 6'd8, {32'd4, 32'd3, 32'h22BB_22DD, 32'd1});
    @(negedge clk);
    check("hold_qv", 128'(bus.q_valid), 128'd0);
    check("hold_q", bus.q, {32'd4, 32'd3, 32'h22BB_22DD, 32'd1});

    // Reset mid-read: completed read visible, then reset with a read in flight.
    read_chk("mr_rd", 6'd62, {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0});
    bus.re = 1'b1; bus.a = 6'd0;
    rst = 1'b1;
    @(negedge clk);
    check("mr_qv", 128'(bus.q_valid), 128'd0);
    check("mr_q", bus.q, 128'd0);
    check("mr_busy", 128'(bus.busy), 128'd1);
    bus.re = 1'b0;
    rst = 1'b0;
    count_fill("mr_fill_cycles");

    // Reset mid-fill restarts the sweep from row 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mf_busy", 128'(bus.busy), 128'd1);
    rst = 1'b0;
    count_fill("mf_fill_cycles");

    // Contents were rewritten by the fill.
    read_chk("refill_60", 6'd60, {4{F}});
    read_chk("refill_8", 6'd8, {4{F}});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
